// File: rtl/ts_sync_lock.sv
// MPEG-2 TS sync acquisition/tracking for one channel: HUNT -> VERIFY -> LOCK with flywheel.
// Optional transport_error_indicator pulse (tei_err) when TS_SYNC_TEI_EN is defined.
module ts_sync_lock #(
  parameter int         PKT_LEN   = 188,
  parameter logic [7:0] SYNC_BYTE = 8'h47,
  parameter int         LOCK_CNT  = 4,
  parameter int         LOSS_CNT  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       out_valid,
  output logic       sop,
  output logic       eop,
  output logic       locked,
`ifdef TS_SYNC_TEI_EN
  output logic       tei_err,
`endif
  output logic       sync_err
);

  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCK = 2'd2} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       vld;
    logic       sop;
    logic       eop;
    logic       locked;
    logic       serr;
  } resp_t;

  localparam logic [7:0] POS_LAST = 8'(PKT_LEN - 1);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N   = 4'(LOSS_CNT);

  state_t     state, state_nxt;
  logic [7:0] pos, pos_nxt, pos_inc;
  logic [3:0] hits, hits_nxt, miss, miss_nxt;
  logic       is_sync, at_sync, lock_hit, loss_hit;
  resp_t      resp, resp_nxt;

  assign is_sync  = (byte_in == SYNC_BYTE);
  assign at_sync  = (pos == 8'd0);
  assign pos_inc  = (pos == POS_LAST) ? 8'd0 : pos + 8'd1;
  assign lock_hit = (hits + 4'd1 == LOCK_N);
  assign loss_hit = (miss + 4'd1 == LOSS_N);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
      pos   <= '0;
      hits  <= '0;
      miss  <= '0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      hits  <= hits_nxt;
      miss  <= miss_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    hits_nxt  = hits;
    miss_nxt  = miss;
    if (byte_valid) begin
      case (state)
        HUNT: if (is_sync) begin
          state_nxt = VERIFY;
          pos_nxt   = 8'd1;
          hits_nxt  = 4'd1;
        end
        VERIFY: begin
          if (!at_sync) pos_nxt = pos_inc;
          else if (is_sync) begin
            hits_nxt = hits + 4'd1;
            pos_nxt  = 8'd1;
            if (lock_hit) begin
              state_nxt = LOCK;
              miss_nxt  = '0;
            end
          end else begin
            // the bad byte is consumed here, not re-tried as a new sync candidate
            state_nxt = HUNT;
            hits_nxt  = '0;
            pos_nxt   = '0;
          end
        end
        LOCK: begin
          if (!at_sync) pos_nxt = pos_inc;
          else if (is_sync) begin
            miss_nxt = '0;
            pos_nxt  = 8'd1;
          end else if (loss_hit) begin
            state_nxt = HUNT;
            pos_nxt   = '0;
            hits_nxt  = '0;
            miss_nxt  = '0;
          end else begin
            miss_nxt = miss + 4'd1;
            pos_nxt  = 8'd1;
          end
        end
        default: begin
          state_nxt = HUNT;
          pos_nxt   = '0;
          hits_nxt  = '0;
          miss_nxt  = '0;
        end
      endcase
    end
  end

  logic fwd, serr;

  always_comb begin
    fwd  = 1'b0;
    serr = 1'b0;
    if (byte_valid) begin
      if (state == LOCK) begin
        serr = at_sync && !is_sync;
        fwd  = !(serr && loss_hit);
      end else if (state == VERIFY) begin
        fwd = at_sync && is_sync && lock_hit;
      end
    end
    resp_nxt        = resp;
    resp_nxt.vld    = fwd;
    resp_nxt.sop    = fwd && at_sync;
    resp_nxt.eop    = fwd && (pos == POS_LAST);
    resp_nxt.locked = (state_nxt == LOCK);
    resp_nxt.serr   = serr;
    if (byte_valid) resp_nxt.data = byte_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) resp <= '0;
    else      resp <= resp_nxt;
  end

  assign byte_out  = resp.data;
  assign out_valid = resp.vld;
  assign sop       = resp.sop;
  assign eop       = resp.eop;
  assign locked    = resp.locked;
  assign sync_err  = resp.serr;

`ifdef TS_SYNC_TEI_EN
  logic tei_lat;

  // pos 1 always follows the sop that cleared the latch, so latch wins on priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tei_lat <= 1'b0;
      tei_err <= 1'b0;
    end else begin
      if (byte_valid && state == LOCK && pos == 8'd1) tei_lat <= byte_in[7];
      else if (fwd && at_sync)                         tei_lat <= 1'b0;
      tei_err <= fwd && (pos == POS_LAST) && tei_lat;
    end
  end
`endif

endmodule

// File: tb/tb_ts_sync_lock.sv
// Directed bench for ts_sync_lock: default 188-byte instance plus a 204-byte instance fed with gaps.
module tb_ts_sync_lock;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] b1 = '0, b2 = '0, bo1, bo2;
  logic v1 = 1'b0, v2 = 1'b0;
  logic ov1, so1, eo1, lk1, se1, ov2, so2, eo2, lk2, se2;
`ifdef TS_SYNC_TEI_EN
  logic te1, te2;
`endif

  ts_sync_lock dut (
    .clk(clk), .rst(rst), .byte_in(b1), .byte_valid(v1), .byte_out(bo1),
    .out_valid(ov1), .sop(so1), .eop(eo1), .locked(lk1),
`ifdef TS_SYNC_TEI_EN
    .tei_err(te1),
`endif
    .sync_err(se1));

  ts_sync_lock #(.PKT_LEN(204)) dut2 (
    .clk(clk), .rst(rst), .byte_in(b2), .byte_valid(v2), .byte_out(bo2),
    .out_valid(ov2), .sop(so2), .eop(eo2), .locked(lk2),
`ifdef TS_SYNC_TEI_EN
    .tei_err(te2),
`endif
    .sync_err(se2));

  int checks = 0, errors = 0;
  int n_ov, n_sop, n_eop, n_err, n_tei, eop_idx, tei_idx, acc;
  logic lk_sop, lk0, lk_end;
  logic [7:0] eop_byte;

`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
      $error("check %s", tag); \
    end \
  end

  task automatic step(input bit sel, input logic [7:0] d, input logic v, input int idx);
    logic ov, so, eo, lk, se, te;
    logic [7:0] bo;
    @(negedge clk);
    if (sel) begin b2 = d; v2 = v; end
    else     begin b1 = d; v1 = v; end
    @(posedge clk);
    #1;
    if (sel) {ov, so, eo, lk, se, bo} = {ov2, so2, eo2, lk2, se2, bo2};
    else     {ov, so, eo, lk, se, bo} = {ov1, so1, eo1, lk1, se1, bo1};
`ifdef TS_SYNC_TEI_EN
    te = sel ? te2 : te1;
`else
    te = 1'b0;
`endif
    if (ov) n_ov++;
    if (ov && so) begin n_sop++; lk_sop = lk; end
    if (ov && eo) begin n_eop++; eop_idx = idx; eop_byte = bo; end
    if (se) n_err++;
    if (te) begin n_tei++; tei_idx = idx; end
    if (idx == 0) lk0 = lk;
    lk_end = lk;
  endtask

  // payload k&63 never equals 8'h47, so only explicit syncs/strays can match
  task automatic pkt(input bit sel, input logic [7:0] sync, input int n, input int stray,
                     input logic [7:0] by1, input bit gaps);
    logic [7:0] d;
    n_ov = 0; n_sop = 0; n_eop = 0; n_err = 0; n_tei = 0;
    eop_idx = -1; tei_idx = -1; lk_sop = 1'b0; eop_byte = '0;
    for (int k = 0; k < n; k++) begin
      d = (k == 0) ? sync : (k == stray) ? 8'h47 : (k == 1) ? by1 : 8'(k & 63);
      step(sel, d, 1'b1, k);
      if (gaps) step(sel, 8'h47, 1'b0, -1);
    end
  endtask

  initial begin
    #12;
    `CHK("rst out_valid", ov1, 1'b0)
    `CHK("rst locked", lk1, 1'b0)
    `CHK("rst sop", so1, 1'b0)
    `CHK("rst eop", eo1, 1'b0)
    `CHK("rst sync_err", se1, 1'b0)
    `CHK("rst byte_out", bo1, 8'h00)
    @(negedge clk) rst = 1'b1;

    for (int p = 1; p <= 6; p++) begin
      pkt(0, 8'h47, 188, -1, 8'h01, 0);
      if (p <= 3) `CHK("prelock fwd", n_ov, 0)
      if (p == 3) `CHK("prelock locked", lk_end, 1'b0)
      if (p == 4) begin
        `CHK("lock sop", n_sop, 1)
        `CHK("lock locked@sop", lk_sop, 1'b1)
        `CHK("lock byte0 locked", lk0, 1'b1)
        `CHK("lock eop byte", eop_byte, 8'h3b)
      end
      if (p >= 4) begin
        `CHK("locked fwd", n_ov, 188)
        `CHK("locked eop cnt", n_eop, 1)
        `CHK("locked eop idx", eop_idx, 187)
        `CHK("clean sync_err", n_err, 0)
      end
    end

    pkt(0, 8'h00, 188, -1, 8'h01, 0);
    `CHK("fly sync_err", n_err, 1)
    `CHK("fly sop", n_sop, 1)
    `CHK("fly fwd", n_ov, 188)
    `CHK("fly locked", lk_end, 1'b1)
    pkt(0, 8'h47, 188, -1, 8'h01, 0);
    `CHK("good after fly", n_err, 0)
    for (int p = 0; p < 2; p++) begin
      pkt(0, 8'h00, 188, -1, 8'h01, 0);
      `CHK("miss sync_err", n_err, 1)
      `CHK("miss still locked", lk_end, 1'b1)
    end
    pkt(0, 8'h00, 188, -1, 8'h01, 0);
    `CHK("loss sync_err", n_err, 1)
    `CHK("loss locked", lk0, 1'b0)
    `CHK("loss fwd", n_ov, 0)

    pkt(0, 8'h47, 188, 50, 8'h01, 0);
    `CHK("verify stray fwd", n_ov, 0)
    pkt(0, 8'h00, 188, -1, 8'h01, 0);
    `CHK("verify bad fwd", n_ov, 0)
    `CHK("verify bad no err", n_err, 0)
    for (int p = 1; p <= 4; p++) begin
      pkt(0, 8'h47, 188, -1, 8'h01, 0);
      if (p < 4) `CHK("relock early", n_ov, 0)
      else begin
        `CHK("relock sop", n_sop, 1)
        `CHK("relock locked@sop", lk_sop, 1'b1)
      end
    end

`ifdef TS_SYNC_TEI_EN
    pkt(0, 8'h47, 188, -1, 8'hC0, 0);
    `CHK("tei count", n_tei, 1)
    `CHK("tei at eop", tei_idx, 187)
    pkt(0, 8'h47, 188, -1, 8'h01, 0);
    `CHK("tei clear", n_tei, 0)
`endif

    pkt(0, 8'h47, 20, -1, 8'h01, 0);
    `CHK("pre-reset fwd", n_ov, 20)
    #2 v1 = 1'b0;
    rst = 1'b0;
    #1;
    `CHK("async out_valid", ov1, 1'b0)
    `CHK("async locked", lk1, 1'b0)
    `CHK("async sop", so1, 1'b0)
    `CHK("async byte_out", bo1, 8'h00)
    #20;
    @(negedge clk) rst = 1'b1;
    acc = 0;
    for (int p = 1; p <= 4; p++) begin
      pkt(0, 8'h47, 188, -1, 8'h01, 0);
      if (p < 4) acc += n_ov;
    end
    `CHK("post-reset prelock", acc, 0)
    `CHK("post-reset lock sop", n_sop, 1)
    @(negedge clk) v1 = 1'b0;

    acc = 0;
    for (int p = 1; p <= 5; p++) begin
      pkt(1, 8'h47, 204, -1, 8'h01, 1);
      acc += n_err;
      if (p <= 3) `CHK("204 prelock", n_ov, 0)
      if (p == 4) begin
        `CHK("204 lock sop", n_sop, 1)
        `CHK("204 locked@sop", lk_sop, 1'b1)
        `CHK("204 eop byte", eop_byte, 8'h0b)
      end
      if (p >= 4) begin
        `CHK("204 fwd", n_ov, 204)
        `CHK("204 eop idx", eop_idx, 203)
      end
    end
    `CHK("204 sync_err", acc, 0)

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
